// File: rtl/pw_pattern_matcher_pkg.sv
// Shared encodings for the sniffed-data pattern matcher.
package pw_pattern_matcher_pkg;

    localparam logic [1:0] PW_ACTION_DISABLED   = 2'b00;
    localparam logic [1:0] PW_ACTION_SINGLE     = 2'b01;
    localparam logic [1:0] PW_ACTION_CONTINUOUS = 2'b10;

    typedef enum logic [1:0] {
        PW_ST_IDLE  = 2'b00,
        PW_ST_ARMED = 2'b01,
        PW_ST_FIRED = 2'b10
    } pw_state_e;

    // 2'b11 is reserved and behaves like disabled.
    function automatic logic pw_action_enabled(input logic [1:0] action);
        return (action != PW_ACTION_DISABLED) && (action != 2'b11);
    endfunction

endpackage

// File: rtl/pw_pattern_matcher_window_cmp.sv
// Combinational masked compare of the newest neff history bytes against the pattern.
module pw_masked_window_cmp #(
    parameter int P  = 8,
    parameter int NW = 4
) (
    input  logic [8*P-1:0] window,
    input  logic [8*P-1:0] pattern,
    input  logic [8*P-1:0] mask,
    input  logic [NW-1:0]  neff,
    output logic           eq
);

    logic mism;

    // window byte 0 is newest; pattern byte 0 is oldest, so they pair up reversed.
    always_comb begin
        mism = 1'b0;
        for (int i = 0; i < P; i++) begin
            for (int j = 0; j < P; j++) begin
                if ((i < int'(neff)) && (j == int'(neff) - 1 - i)) begin
                    mism = mism | (|((window[8*i +: 8] ^ pattern[8*j +: 8]) & mask[8*j +: 8]));
                end
            end
        end
        eq = (neff != '0) && !mism;
    end

endmodule

// File: rtl/pw_pattern_matcher.sv
// Sliding-history pattern matcher on sniffed USB data; emits a registered match pulse.
//
// state | meaning
// IDLE  | disarmed; history and fill held
// ARMED | shifting in data and comparing each new window
// FIRED | single-shot match seen; data ignored until disarm
module pw_pattern_matcher
    import pw_pattern_matcher_pkg::*;
#(
    parameter int pPATTERN_BYTES     = 8,
    parameter int pMATCH_COUNT_WIDTH = 16,
    localparam int FW = $clog2(pPATTERN_BYTES + 1)
) (
    input  logic                            fe_clk,
    input  logic                            reset_i,
    input  logic                            I_arm,
    input  logic [7:0]                      I_data,
    input  logic                            I_data_wr,
    input  logic                            I_clear,
    input  logic [8*pPATTERN_BYTES-1:0]     I_pattern,
    input  logic [8*pPATTERN_BYTES-1:0]     I_pattern_mask,
    input  logic [1:0]                      I_pattern_action,
    input  logic [7:0]                      I_pattern_bytes,
    output logic                            O_match,
    output logic                            O_armed,
    output logic [FW-1:0]                   O_fill,
    output logic [pMATCH_COUNT_WIDTH-1:0]   O_match_count
);

    localparam int         P    = pPATTERN_BYTES;
    localparam logic [7:0] P_B  = 8'(P);
    localparam logic [FW-1:0] P_FW = FW'(P);

    pw_state_e            state;
    logic [8*P-1:0]       hist;
    logic [8*P-1:0]       hist_next;
    logic [FW-1:0]        fill;
    logic [FW-1:0]        fill_base;
    logic [FW-1:0]        fill_next;
    logic [FW-1:0]        neff;
    logic                 win_eq;
    logic                 match_now;

    always_comb begin
        neff = (I_pattern_bytes >= P_B) ? P_FW : FW'(I_pattern_bytes);
    end

    // Clear applies before the same-cycle byte is inserted.
    always_comb begin
        fill_base = I_clear ? '0 : fill;
        fill_next = fill_base;
        hist_next = hist;
        if (I_data_wr) begin
            hist_next = {hist[8*P-9:0], I_data};
            if (fill_base < P_FW) begin
                fill_next = fill_base + FW'(1);
            end
        end
    end

    pw_masked_window_cmp #(
        .P  (P),
        .NW (FW)
    ) u_cmp (
        .window  (hist_next),
        .pattern (I_pattern),
        .mask    (I_pattern_mask),
        .neff    (neff),
        .eq      (win_eq)
    );

    assign match_now = (state == PW_ST_ARMED) && I_arm && I_data_wr && win_eq
                       && (fill_next >= neff);

    always_ff @(posedge fe_clk or posedge reset_i) begin
        if (reset_i) begin
            state         <= PW_ST_IDLE;
            hist          <= '0;
            fill          <= '0;
            O_match       <= 1'b0;
            O_match_count <= '0;
        end else begin
            O_match <= 1'b0;
            case (state)
                PW_ST_IDLE: begin
                    if (I_arm && pw_action_enabled(I_pattern_action) && (neff != '0)) begin
                        state         <= PW_ST_ARMED;
                        fill          <= '0;
                        O_match_count <= '0;
                    end
                end
                PW_ST_ARMED: begin
                    if (!I_arm) begin
                        state <= PW_ST_IDLE;
                    end else begin
                        hist <= hist_next;
                        fill <= fill_next;
                        if (match_now) begin
                            O_match <= 1'b1;
                            if (!(&O_match_count)) begin
                                O_match_count <= O_match_count + 1'b1;
                            end
                            // Continuous mode restarts the window so matches never overlap.
                            if (I_pattern_action == PW_ACTION_CONTINUOUS) begin
                                fill <= '0;
                            end else begin
                                state <= PW_ST_FIRED;
                            end
                        end
                    end
                end
                PW_ST_FIRED: begin
                    if (!I_arm) begin
                        state <= PW_ST_IDLE;
                    end
                end
                default: state <= PW_ST_IDLE;
            endcase
        end
    end

    assign O_armed = (state == PW_ST_ARMED);
    assign O_fill  = fill;

endmodule

// File: tb/tb_pw_pattern_matcher.sv
// Directed bench for pw_pattern_matcher; a second instance uses a 2-bit counter.
module tb_pw_pattern_matcher;

    logic        fe_clk = 1'b0;
    logic        reset_i;
    logic        I_arm;
    logic [7:0]  I_data;
    logic        I_data_wr;
    logic        I_clear;
    logic [63:0] I_pattern;
    logic [63:0] I_pattern_mask;
    logic [1:0]  I_pattern_action;
    logic [7:0]  I_pattern_bytes;

    logic        O_match;
    logic        O_armed;
    logic [3:0]  O_fill;
    logic [15:0] O_match_count;

    logic        sat_match;
    logic        sat_armed;
    logic [3:0]  sat_fill;
    logic [1:0]  sat_count;

    int n_pass  = 0;
    int n_total = 0;
    int pulse_cnt = 0;

    always #5 fe_clk = ~fe_clk;

    always @(negedge fe_clk) if (O_match === 1'b1) pulse_cnt++;

    pw_pattern_matcher #(.pPATTERN_BYTES(8), .pMATCH_COUNT_WIDTH(16)) dut (
        .fe_clk(fe_clk), .reset_i(reset_i), .I_arm(I_arm), .I_data(I_data),
        .I_data_wr(I_data_wr), .I_clear(I_clear), .I_pattern(I_pattern),
        .I_pattern_mask(I_pattern_mask), .I_pattern_action(I_pattern_action),
        .I_pattern_bytes(I_pattern_bytes), .O_match(O_match), .O_armed(O_armed),
        .O_fill(O_fill), .O_match_count(O_match_count)
    );

    pw_pattern_matcher #(.pPATTERN_BYTES(8), .pMATCH_COUNT_WIDTH(2)) dut_sat (
        .fe_clk(fe_clk), .reset_i(reset_i), .I_arm(I_arm), .I_data(I_data),
        .I_data_wr(I_data_wr), .I_clear(I_clear), .I_pattern(I_pattern),
        .I_pattern_mask(I_pattern_mask), .I_pattern_action(I_pattern_action),
        .I_pattern_bytes(I_pattern_bytes), .O_match(sat_match), .O_armed(sat_armed),
        .O_fill(sat_fill), .O_match_count(sat_count)
    );

    task automatic tick();
        @(posedge fe_clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b, input logic clr);
        I_data    = b;
        I_data_wr = 1'b1;
        I_clear   = clr;
        tick();
        I_data_wr = 1'b0;
        I_clear   = 1'b0;
    endtask

    task automatic cfg3(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                        input logic [7:0] n, input logic [1:0] act);
        I_pattern        = '0;
        I_pattern[7:0]   = b0;
        I_pattern[15:8]  = b1;
        I_pattern[23:16] = b2;
        I_pattern_mask   = '1;
        I_pattern_bytes  = n;
        I_pattern_action = act;
    endtask

    task automatic arm();
        I_arm = 1'b1;
        tick();
    endtask

    task automatic disarm();
        I_arm = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        n_total++; if (O_match !== 1'b0) $display("FAIL reset_match got %0b exp 0", O_match); else n_pass++;
        n_total++; if (O_armed !== 1'b0) $display("FAIL reset_armed got %0b exp 0", O_armed); else n_pass++;
        n_total++; if (O_fill !== 4'd0) $display("FAIL reset_fill got %0d exp 0", O_fill); else n_pass++;
        n_total++; if (O_match_count !== 16'd0) $display("FAIL reset_count got %0d exp 0", O_match_count); else n_pass++;
    endtask

    task automatic test_single();
        int p0;
        cfg3(8'hA5, 8'h5A, 8'hFF, 8'd3, 2'b01);
        arm();
        n_total++; if (O_armed !== 1'b1) $display("FAIL single_armed got %0b exp 1", O_armed); else n_pass++;
        send(8'h00, 1'b0);
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        n_total++; if (O_match !== 1'b0) $display("FAIL single_early got %0b exp 0", O_match); else n_pass++;
        send(8'hFF, 1'b0);
        n_total++; if (O_match !== 1'b1) $display("FAIL single_match got %0b exp 1", O_match); else n_pass++;
        n_total++; if (O_armed !== 1'b0) $display("FAIL single_fired got armed=%0b exp 0", O_armed); else n_pass++;
        n_total++; if (O_match_count !== 16'd1) $display("FAIL single_count got %0d exp 1", O_match_count); else n_pass++;
        n_total++; if (O_fill !== 4'd4) $display("FAIL single_fill got %0d exp 4", O_fill); else n_pass++;
        tick();
        n_total++; if (O_match !== 1'b0) $display("FAIL single_one_cycle got %0b exp 0", O_match); else n_pass++;
        p0 = pulse_cnt;
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        send(8'hFF, 1'b0);
        tick();
        n_total++; if (pulse_cnt !== p0) $display("FAIL fired_ignores got %0d pulses exp %0d", pulse_cnt, p0); else n_pass++;
        n_total++; if (O_match_count !== 16'd1) $display("FAIL fired_count got %0d exp 1", O_match_count); else n_pass++;
        disarm();
    endtask

    task automatic test_mask();
        logic [63:0] m;
        cfg3(8'hA5, 8'h5A, 8'hFF, 8'd3, 2'b01);
        m = '1;
        m[15:8] = 8'h00;
        I_pattern_mask = m;
        arm();
        send(8'hA5, 1'b0);
        send(8'h12, 1'b0);
        send(8'hFF, 1'b0);
        n_total++; if (O_match !== 1'b1) $display("FAIL mask_dontcare got %0b exp 1", O_match); else n_pass++;
        disarm();
        arm();
        send(8'hA4, 1'b0);
        send(8'h5A, 1'b0);
        send(8'hFF, 1'b0);
        n_total++; if (O_match !== 1'b0) $display("FAIL mask_mismatch got %0b exp 0", O_match); else n_pass++;
        n_total++; if (O_armed !== 1'b1) $display("FAIL mask_still_armed got %0b exp 1", O_armed); else n_pass++;
        n_total++; if (O_fill !== 4'd3) $display("FAIL mask_fill got %0d exp 3", O_fill); else n_pass++;
        disarm();
    endtask

    task automatic test_continuous();
        int p0;
        cfg3(8'h11, 8'h22, 8'h00, 8'd2, 2'b10);
        arm();
        p0 = pulse_cnt;
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        n_total++; if (O_match !== 1'b1) $display("FAIL cont_first got %0b exp 1", O_match); else n_pass++;
        n_total++; if (O_fill !== 4'd0) $display("FAIL cont_fill_clr got %0d exp 0", O_fill); else n_pass++;
        send(8'h22, 1'b0);
        send(8'h11, 1'b0);
        n_total++; if (O_match !== 1'b0) $display("FAIL cont_reversed got %0b exp 0", O_match); else n_pass++;
        send(8'h22, 1'b0);
        n_total++; if (O_match !== 1'b1) $display("FAIL cont_second got %0b exp 1", O_match); else n_pass++;
        tick();
        n_total++; if (pulse_cnt !== p0 + 2) $display("FAIL cont_pulses got %0d exp %0d", pulse_cnt - p0, 2); else n_pass++;
        n_total++; if (O_match_count !== 16'd2) $display("FAIL cont_count got %0d exp 2", O_match_count); else n_pass++;
        n_total++; if (O_armed !== 1'b1) $display("FAIL cont_armed got %0b exp 1", O_armed); else n_pass++;
        disarm();
    endtask

    task automatic test_clear();
        cfg3(8'hA5, 8'h5A, 8'hFF, 8'd3, 2'b01);
        arm();
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        send(8'hFF, 1'b1);
        n_total++; if (O_match !== 1'b0) $display("FAIL clear_no_match got %0b exp 0", O_match); else n_pass++;
        n_total++; if (O_fill !== 4'd1) $display("FAIL clear_fill got %0d exp 1", O_fill); else n_pass++;
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        send(8'hFF, 1'b0);
        n_total++; if (O_match !== 1'b1) $display("FAIL clear_rematch got %0b exp 1", O_match); else n_pass++;
        disarm();
    endtask

    task automatic test_n_zero();
        cfg3(8'hA5, 8'h5A, 8'hFF, 8'd0, 2'b01);
        arm();
        tick();
        n_total++; if (O_armed !== 1'b0) $display("FAIL nzero_armed got %0b exp 0", O_armed); else n_pass++;
        disarm();
    endtask

    task automatic test_n_large();
        I_pattern        = 64'h0807_0605_0403_0201;
        I_pattern_mask   = '1;
        I_pattern_bytes  = 8'd200;
        I_pattern_action = 2'b01;
        arm();
        for (int k = 1; k <= 7; k++) send(8'(k), 1'b0);
        n_total++; if (O_match !== 1'b0) $display("FAIL nlarge_seven got %0b exp 0", O_match); else n_pass++;
        n_total++; if (O_fill !== 4'd7) $display("FAIL nlarge_fill got %0d exp 7", O_fill); else n_pass++;
        send(8'h08, 1'b0);
        n_total++; if (O_match !== 1'b1) $display("FAIL nlarge_eight got %0b exp 1", O_match); else n_pass++;
        disarm();
    endtask

    task automatic test_arm_drop();
        cfg3(8'hA5, 8'h5A, 8'hFF, 8'd3, 2'b01);
        arm();
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        I_arm = 1'b0;
        send(8'hFF, 1'b0);
        n_total++; if (O_match !== 1'b0) $display("FAIL armdrop_match got %0b exp 0", O_match); else n_pass++;
        n_total++; if (O_armed !== 1'b0) $display("FAIL armdrop_state got %0b exp 0", O_armed); else n_pass++;
        n_total++; if (O_match_count !== 16'd0) $display("FAIL armdrop_count got %0d exp 0", O_match_count); else n_pass++;
        n_total++; if (O_fill !== 4'd2) $display("FAIL armdrop_fill got %0d exp 2", O_fill); else n_pass++;
    endtask

    task automatic test_saturation();
        cfg3(8'h11, 8'h22, 8'h00, 8'd2, 2'b10);
        arm();
        for (int k = 0; k < 5; k++) begin
            send(8'h11, 1'b0);
            send(8'h22, 1'b0);
        end
        n_total++; if (O_match_count !== 16'd5) $display("FAIL sat_wide got %0d exp 5", O_match_count); else n_pass++;
        n_total++; if (sat_count !== 2'd3) $display("FAIL sat_narrow got %0d exp 3", sat_count); else n_pass++;
        disarm();
    endtask

    task automatic test_async_reset();
        cfg3(8'hA5, 8'h5A, 8'hFF, 8'd3, 2'b01);
        arm();
        send(8'hA5, 1'b0);
        send(8'h5A, 1'b0);
        send(8'hFF, 1'b0);
        n_total++; if (O_match !== 1'b1) $display("FAIL arst_pre_match got %0b exp 1", O_match); else n_pass++;
        #2;
        reset_i = 1'b1;
        #1;
        n_total++; if (O_match !== 1'b0) $display("FAIL arst_match got %0b exp 0", O_match); else n_pass++;
        n_total++; if (O_fill !== 4'd0) $display("FAIL arst_fill got %0d exp 0", O_fill); else n_pass++;
        n_total++; if (O_match_count !== 16'd0) $display("FAIL arst_count got %0d exp 0", O_match_count); else n_pass++;
        I_arm = 1'b0;
        tick();
        reset_i = 1'b0;
        tick();
        n_total++; if (O_armed !== 1'b0) $display("FAIL arst_idle got %0b exp 0", O_armed); else n_pass++;
    endtask

    initial begin
        reset_i          = 1'b1;
        I_arm            = 1'b0;
        I_data           = 8'h00;
        I_data_wr        = 1'b0;
        I_clear          = 1'b0;
        I_pattern        = '0;
        I_pattern_mask   = '0;
        I_pattern_action = 2'b00;
        I_pattern_bytes  = 8'd0;
        #12;
        test_reset();
        reset_i = 1'b0;
        tick();
        test_single();
        test_mask();
        test_continuous();
        test_clear();
        test_n_zero();
        test_n_large();
        test_arm_drop();
        test_saturation();
        test_async_reset();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/pw_pattern_matcher.md
Name: pw_pattern_matcher

Overview:
- Sits between the front-end USB byte decoder and the trigger generator, in the fe_clk domain.
- Keeps a sliding history of the most recent sniffed data bytes and compares the newest pattern-length window against the masked pattern programmed over USB.
- Emits a single-cycle match pulse, I_match for the register block, and tracks how many times it has matched.

Parameters:
- pPATTERN_BYTES, 8: history/pattern depth in bytes (P).
- pMATCH_COUNT_WIDTH, 16: width of the saturating match counter.

Ports:
- fe_clk  in  1  capture clock; sole clock.
- reset_i  in  1  asynchronous, active-high reset.
- I_arm  in  1  arm level, already synchronised to fe_clk.
- I_data  in  8  sniffed data byte.
- I_data_wr  in  1  I_data valid this cycle.
- I_clear  in  1  packet-boundary pulse; empties history.
- I_pattern  in  8*P  pattern; byte k = I_pattern[8k +: 8], byte 0 is oldest.
- I_pattern_mask  in  8*P  per-bit compare enable (1 = compare, 0 = don't care).
- I_pattern_action  in  2  00 = disabled, 01 = single-shot, 10 = continuous, 11 = treated as 00.
- I_pattern_bytes  in  8  pattern length N.
- O_match  out  1  one-cycle match pulse.
- O_armed  out  1  state == ARMED.
- O_fill  out  clog2(P+1)  valid bytes in history.
- O_match_count  out  pMATCH_COUNT_WIDTH  matches since last arm.

Behaviour:
- Reset values: all outputs 0, history 0, state IDLE.
- Configuration inputs are quasi-static; software changes them only while disarmed. No CDC logic in this block.
- Effective length Neff = min(I_pattern_bytes, P). Neff = 0 means never match.
- History:
  - P-byte shift register; hist byte 0 is the newest.
  - On I_data_wr: shift left by one byte, insert I_data, fill = min(fill+1, P).
  - I_clear sets fill to 0.
  - If I_clear and I_data_wr occur in the same cycle: clear first, then insert the byte, so fill = 1.
- Compare:
  - Evaluated combinationally on the post-shift window, including the incoming byte.
  - For each i < Neff, ((hist_next[i] XOR pattern[Neff-1-i]) AND mask[Neff-1-i]) must equal 0.
  - Also requires fill_next >= Neff, I_data_wr = 1 and state == ARMED.
- Latency: O_match is registered and asserts on the cycle after the I_data_wr that completes the pattern. It is never asserted for two consecutive cycles from the same byte.
- States:
  - IDLE: entered on reset. Moves to ARMED when I_arm = 1, action is 01 or 10, and Neff != 0. On entry to ARMED: fill cleared and O_match_count cleared.
  - ARMED: I_arm = 0 returns to IDLE, with no match pulse that cycle even if the compare is true.
  - ARMED, match with action 01: go to FIRED.
  - ARMED, match with action 10: stay ARMED and clear fill, so matches never overlap. The next match needs Neff fresh bytes.
  - FIRED: ignores data; returns to IDLE when I_arm = 0. This stops re-triggering while the USB-side disarm propagates back.
- Fill is held, not cleared, in IDLE and FIRED. It is cleared on the IDLE->ARMED transition.
- O_match_count increments on each O_match and saturates at its maximum value.
- Asynchronous reset mid-operation: everything returns to reset values immediately; no pulse is emitted.

Decomposition:
- Shared package/defines (defines.v): action encodings PW_ACTION_DISABLED/SINGLE/CONTINUOUS, state encodings.
- One natural sub-module, pw_masked_window_cmp: combinational masked compare with variable Neff, so it can be unit-tested separately.
- State machine, history, counter and pulse register stay in the top module.

Test Plan:
- P = 8, N = 3, pattern bytes 0..2 = A5,5A,FF, mask all FF, action 01; arm, feed 00,A5,5A,FF -> O_match pulses once, the cycle after FF; state FIRED; count = 1; further A5,5A,FF gives no pulse until I_arm drops.
- Same setup but mask byte 1 = 00; feed A5,12,FF -> match. Feed A4,5A,FF -> no match.
- Action 10, N = 2, pattern 11,22; feed 11,22,22,11,22 -> exactly two pulses, after byte 2 and byte 5; count = 2.
- N = 3; feed A5,5A, then I_clear together with I_data_wr of FF -> no match, fill = 1; then A5,5A,FF -> match.
- Boundaries: N = 0 -> stays IDLE when armed. N = 200 -> behaves as N = 8 (match after 8 correct bytes, none after 7). I_arm drops the same cycle a match completes -> no pulse.
- Count saturation with width forced to 2: 5 matches in continuous mode -> count stays at 3. Assert reset_i mid-stream -> O_match, O_fill and O_match_count go to 0 immediately.
